// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: one write port, clear
// request, NRD packed read ports and the clear-in-progress flag.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4,
  parameter int NRD   = 3
);
  logic                 wr;
  logic                 ce;
  logic [AW-1:0]        wadr;
  logic [WIDTH-1:0]     din;
  logic                 clr;
  logic [NRD*AW-1:0]    radr;
  logic [NRD*WIDTH-1:0] dout;
  logic                 busy;

  modport master (
    output wr, ce, wadr, din, clr, radr,
    input  dout, busy
  );

  modport slave (
    input  wr, ce, wadr, din, clr, radr,
    output dout, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NRD combinational read ports,
// each read port backed by its own replica of the array. A two-state clear
// sequencer zeroes every entry after reset or on request; while it runs,
// writes are dropped and all read ports return zero.
module regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int AW      = 4,
  parameter int NRD     = 3,
  parameter int BYPASS  = 0,
  parameter int ZERO_R0 = 0
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);

  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    cnt;
  logic             busy;
  logic             clear_we;
  logic             user_we;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;

  // State register; reset lands in CLEAR so the array is zeroed after reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nx;
  end

  // Next-state logic: clr starts a sweep only from IDLE; the sweep ends on
  // the edge that clears the last entry.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.clr)      state_nx = CLEAR;
      CLEAR:   if (cnt == LAST)  state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  // Output decode straight from the state flop, so busy cannot glitch.
  always_comb begin
    busy     = 1'b0;
    clear_we = 1'b0;
    if (state == CLEAR) begin
      busy     = 1'b1;
      clear_we = 1'b1;
    end
  end

  // Sweep pointer: advances every clock in CLEAR (ce does not stall it) and
  // wraps to zero on the same edge that returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
    else                     cnt <= '0;
  end

  assign user_we  = bus.wr & bus.ce & ~busy;
  assign bus.busy = busy;

  // Shared write port: the sweep and user writes are mutually exclusive
  // because user writes are gated off while busy.
  always_comb begin
    we = user_we | clear_we;
    wa = bus.wadr;
    wd = bus.din;
    if (clear_we) begin
      wa = cnt;
      wd = '0;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = bus.radr[k*AW +: AW];

    // Replica write: every copy sees the identical write stream.
    // NOTE: the array has no reset; zeroing is done by the clear sweep,
    // which keeps it mappable to plain RAM/flop arrays without reset muxes.
    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
    end

    // Read path: optional forwarding, then register-0 and busy forcing.
    always_comb begin
      rd = mem[ra];
      if ((BYPASS != 0) && user_we && (ra == bus.wadr)) rd = bus.din;
      if ((ZERO_R0 != 0) && (ra == '0))                 rd = '0;
      if (busy)                                         rd = '0;
    end

    assign bus.dout[k*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default build (AW=4, NRD=3, no bypass)
// and a wide build (AW=5, NRD=5, BYPASS=1, ZERO_R0=1).
module tb_regfile_mp;

  logic clk;
  logic rst;
  logic rst2;
  int   vec  = 0;
  int   errs = 0;

  regfile_mp_if #(.WIDTH(32), .AW(4), .NRD(3)) bus_a ();
  regfile_mp_if #(.WIDTH(32), .AW(5), .NRD(5)) bus_b ();

  regfile_mp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  regfile_mp #(
    .WIDTH   (32),
    .AW      (5),
    .NRD     (5),
    .BYPASS  (1),
    .ZERO_R0 (1)
  ) dut_b (
    .clk (clk),
    .rst (rst2),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count cycles with busy high on the default build; also notes any
  // nonzero read seen while busy.
  task automatic count_busy_a(output int n, output bit zero_ok);
    n = 0;
    zero_ok = 1'b1;
    while (bus_a.busy === 1'b1 && n < 200) begin
      if (bus_a.dout !== '0) zero_ok = 1'b0;
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic check_all_zero_a(input string name);
    for (int a = 0; a < 16; a++) begin
      bus_a.radr = {3{4'(a)}};
      #1;
      vec++;
      if (bus_a.dout !== '0) begin
        errs++;
        $display("FAIL %s reg %0d: got %h expected 0", name, a, bus_a.dout);
      end
    end
  endtask

  task automatic write_a(input logic [3:0] adr, input logic [31:0] d);
    @(negedge clk);
    bus_a.wr = 1'b1; bus_a.ce = 1'b1; bus_a.wadr = adr; bus_a.din = d;
    @(negedge clk);
    bus_a.wr = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    bit zok;
    @(negedge clk);
    bus_a.radr = {4'd1, 4'd2, 4'd3};
    #1;
    vec++;
    if (bus_a.busy !== 1'b1) begin
      errs++; $display("FAIL reset_busy: got %b expected 1", bus_a.busy);
    end
    vec++;
    if (bus_a.dout !== '0) begin
      errs++; $display("FAIL reset_dout: got %h expected 0", bus_a.dout);
    end
    rst = 1'b1;
    count_busy_a(n, zok);
    vec++;
    if (n !== 16) begin
      errs++; $display("FAIL reset_busy_cycles: got %0d expected 16", n);
    end
    vec++;
    if (!zok) begin
      errs++; $display("FAIL reset_dout_busy: got nonzero expected 0");
    end
    check_all_zero_a("reset_zero");
  endtask

  task automatic test_write_bypass;
    @(negedge clk);
    bus_a.wr = 1'b1; bus_a.ce = 1'b1; bus_a.wadr = 4'd5;
    bus_a.din = 32'hDEADBEEF; bus_a.radr = {3{4'd5}};
    #1;
    vec++;
    if (bus_a.dout !== '0) begin
      errs++; $display("FAIL write_same_cycle: got %h expected 0", bus_a.dout);
    end
    @(negedge clk);
    bus_a.wr = 1'b0;
    #1;
    vec++;
    if (bus_a.dout !== {3{32'hDEADBEEF}}) begin
      errs++; $display("FAIL write_next_cycle: got %h expected %h", bus_a.dout, {3{32'hDEADBEEF}});
    end
  endtask

  task automatic test_ce_gate;
    write_a(4'd3, 32'hA5A5A5A5);
    @(negedge clk);
    bus_a.wr = 1'b1; bus_a.ce = 1'b0; bus_a.wadr = 4'd3;
    bus_a.din = 32'h12345678; bus_a.radr = {3{4'd3}};
    #1;
    vec++;
    if (bus_a.dout !== {3{32'hA5A5A5A5}}) begin
      errs++; $display("FAIL ce_gate_same: got %h expected %h", bus_a.dout, {3{32'hA5A5A5A5}});
    end
    @(negedge clk);
    bus_a.wr = 1'b0; bus_a.ce = 1'b1;
    #1;
    vec++;
    if (bus_a.dout !== {3{32'hA5A5A5A5}}) begin
      errs++; $display("FAIL ce_gate_next: got %h expected %h", bus_a.dout, {3{32'hA5A5A5A5}});
    end
  endtask

  task automatic test_multi_read;
    @(negedge clk);
    bus_a.radr = {4'd0, 4'd3, 4'd5};
    #1;
    vec++;
    if (bus_a.dout !== {32'h0, 32'hA5A5A5A5, 32'hDEADBEEF}) begin
      errs++; $display("FAIL multi_read: got %h expected %h", bus_a.dout,
                       {32'h0, 32'hA5A5A5A5, 32'hDEADBEEF});
    end
  endtask

  task automatic test_clear;
    int n;
    bit zok;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus_a.wr = 1'b1; bus_a.ce = 1'b1; bus_a.wadr = 4'(i);
      bus_a.din = 32'(i) * 32'h11111111;
    end
    @(negedge clk);
    bus_a.wr = 1'b0;
    bus_a.radr = {4'd1, 4'd7, 4'd15};
    #1;
    vec++;
    if (bus_a.dout !== {32'h11111111, 32'h77777777, 32'hFFFFFFFF}) begin
      errs++; $display("FAIL fill_a: got %h expected %h", bus_a.dout,
                       {32'h11111111, 32'h77777777, 32'hFFFFFFFF});
    end
    bus_a.radr = {4'd5, 4'd10, 4'd0};
    #1;
    vec++;
    if (bus_a.dout !== {32'h55555555, 32'hAAAAAAAA, 32'h0}) begin
      errs++; $display("FAIL fill_b: got %h expected %h", bus_a.dout,
                       {32'h55555555, 32'hAAAAAAAA, 32'h0});
    end
    @(negedge clk);
    bus_a.clr = 1'b1;
    bus_a.radr = {4'd0, 4'd5, 4'd7};
    #1;
    vec++;
    if (bus_a.busy !== 1'b0) begin
      errs++; $display("FAIL clr_pre_edge_busy: got %b expected 0", bus_a.busy);
    end
    @(negedge clk);
    bus_a.clr = 1'b0;
    #1;
    n = 0;
    zok = 1'b1;
    while (bus_a.busy === 1'b1 && n < 200) begin
      if (bus_a.dout !== '0) zok = 1'b0;
      n++;
      if (n == 3) begin
        bus_a.wr = 1'b1; bus_a.ce = 1'b1; bus_a.wadr = 4'd7; bus_a.din = 32'hDEADBEEF;
      end
      if (n == 4) bus_a.wr = 1'b0;
      if (n == 5) bus_a.clr = 1'b1;
      if (n == 6) bus_a.clr = 1'b0;
      @(negedge clk); #1;
    end
    bus_a.wr  = 1'b0;
    bus_a.clr = 1'b0;
    vec++;
    if (n !== 16) begin
      errs++; $display("FAIL clear_busy_cycles: got %0d expected 16", n);
    end
    vec++;
    if (!zok) begin
      errs++; $display("FAIL clear_dout_busy: got nonzero expected 0");
    end
    check_all_zero_a("clear_zero");
  endtask

  task automatic test_rst_mid_clear;
    int n;
    bit zok;
    write_a(4'd9, 32'h99999999);
    bus_a.radr = {3{4'd9}};
    #1;
    vec++;
    if (bus_a.dout !== {3{32'h99999999}}) begin
      errs++; $display("FAIL pre_rst_write: got %h expected %h", bus_a.dout, {3{32'h99999999}});
    end
    @(negedge clk);
    bus_a.clr = 1'b1;
    @(negedge clk);
    bus_a.clr = 1'b0;
    #1;
    n = 0;
    while (bus_a.busy === 1'b1 && n < 8) begin
      n++;
      @(negedge clk); #1;
    end
    rst = 1'b0;
    #1;
    vec++;
    if (bus_a.busy !== 1'b1) begin
      errs++; $display("FAIL mid_rst_busy: got %b expected 1", bus_a.busy);
    end
    vec++;
    if (bus_a.dout !== '0) begin
      errs++; $display("FAIL mid_rst_dout: got %h expected 0", bus_a.dout);
    end
    @(negedge clk);
    rst = 1'b1;
    count_busy_a(n, zok);
    vec++;
    if (n !== 16) begin
      errs++; $display("FAIL mid_rst_busy_cycles: got %0d expected 16", n);
    end
    check_all_zero_a("mid_rst_zero");
  endtask

  task automatic test_wide_zero_r0;
    int n;
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    n = 0;
    while (bus_b.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    vec++;
    if (n !== 32) begin
      errs++; $display("FAIL wide_busy_cycles: got %0d expected 32", n);
    end
    @(negedge clk);
    bus_b.wr = 1'b1; bus_b.ce = 1'b1; bus_b.wadr = 5'd0;
    bus_b.din = 32'hFFFFFFFF; bus_b.radr = {5{5'd0}};
    #1;
    vec++;
    if (bus_b.dout !== '0) begin
      errs++; $display("FAIL r0_bypass: got %h expected 0", bus_b.dout);
    end
    @(negedge clk);
    bus_b.wr = 1'b0;
    #1;
    vec++;
    if (bus_b.dout !== '0) begin
      errs++; $display("FAIL r0_stored: got %h expected 0", bus_b.dout);
    end
    @(negedge clk);
    bus_b.wr = 1'b1; bus_b.wadr = 5'd1;  bus_b.din = 32'h01010101;
    @(negedge clk);
    bus_b.wadr = 5'd10; bus_b.din = 32'h0A0A0A0A;
    @(negedge clk);
    bus_b.wadr = 5'd20; bus_b.din = 32'h14141414;
    @(negedge clk);
    bus_b.wadr = 5'd31; bus_b.din = 32'h1F1F1F1F;
    bus_b.radr = {5'd0, 5'd1, 5'd10, 5'd20, 5'd31};
    #1;
    vec++;
    if (bus_b.dout !== {32'h0, 32'h01010101, 32'h0A0A0A0A, 32'h14141414, 32'h1F1F1F1F}) begin
      errs++; $display("FAIL wide_bypass: got %h expected %h", bus_b.dout,
                       {32'h0, 32'h01010101, 32'h0A0A0A0A, 32'h14141414, 32'h1F1F1F1F});
    end
    @(negedge clk);
    bus_b.wr = 1'b0;
    #1;
    vec++;
    if (bus_b.dout !== {32'h0, 32'h01010101, 32'h0A0A0A0A, 32'h14141414, 32'h1F1F1F1F}) begin
      errs++; $display("FAIL wide_stored: got %h expected %h", bus_b.dout,
                       {32'h0, 32'h01010101, 32'h0A0A0A0A, 32'h14141414, 32'h1F1F1F1F});
    end
    bus_b.radr = {5'd31, 5'd1, 5'd20, 5'd0, 5'd10};
    #1;
    vec++;
    if (bus_b.dout !== {32'h1F1F1F1F, 32'h01010101, 32'h14141414, 32'h0, 32'h0A0A0A0A}) begin
      errs++; $display("FAIL wide_permuted: got %h expected %h", bus_b.dout,
                       {32'h1F1F1F1F, 32'h01010101, 32'h14141414, 32'h0, 32'h0A0A0A0A});
    end
  endtask

  initial begin
    rst  = 1'b0;
    rst2 = 1'b0;
    bus_a.wr = 1'b0; bus_a.ce = 1'b0; bus_a.wadr = '0; bus_a.din = '0;
    bus_a.clr = 1'b0; bus_a.radr = '0;
    bus_b.wr = 1'b0; bus_b.ce = 1'b0; bus_b.wadr = '0; bus_b.din = '0;
    bus_b.clr = 1'b0; bus_b.radr = '0;

    test_reset;
    test_write_bypass;
    test_ce_gate;
    test_multi_read;
    test_clear;
    test_rst_mid_clear;
    test_wide_zero_r0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL provide parameter AW, default 4, address bits; DEPTH = 2**AW registers.
REQ-003 SHALL provide parameter NRD, default 3, number of independent read ports (1..8).
REQ-004 SHALL provide parameter BYPASS, default 0: 1 = write-to-read forwarding enabled.
REQ-005 SHALL provide parameter ZERO_R0, default 0: 1 = register 0 always reads zero.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 wr  input  1  write request.
REQ-009 ce  input  1  clock enable; write takes effect only when wr & ce.
REQ-010 wadr  input  AW  write address.
REQ-011 din  input  WIDTH  write data.
REQ-012 clr  input  1  request a full clear of all registers to zero.
REQ-013 radr  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
REQ-014 dout  output  NRD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH].
REQ-015 busy  output  1  high while clear sequence runs.

Function
REQ-016 SHALL implement a DEPTH x WIDTH storage array written through one port and read through NRD ports, each read port a replicated copy kept identical by every write.
REQ-017 Reads SHALL be combinational: dout port k = array[radr port k] in the same cycle, no clock latency.
REQ-018 Write SHALL occur on the rising edge when wr & ce & ~busy; new value visible on reads from the following cycle.
REQ-019 With BYPASS=0, a read of wadr during a write cycle SHALL return the old value; with BYPASS=1 it SHALL return din.
REQ-020 With ZERO_R0=1, any read of address 0 SHALL return 0 regardless of contents or bypass; writes to address 0 are still performed.
REQ-021 Clear FSM SHALL have two states: CLEAR and IDLE.
REQ-022 In CLEAR, each clock edge SHALL write 0 to array[cnt] and increment cnt (AW bits); when cnt = DEPTH-1 the FSM SHALL go to IDLE on that same edge.
REQ-023 CLEAR SHALL therefore last exactly DEPTH cycles; busy SHALL be 1 in CLEAR and 0 in IDLE (registered state decode, no glitches).
REQ-024 In IDLE, clr=1 sampled on an edge SHALL enter CLEAR with cnt=0 on that edge; write requests in that same cycle SHALL still be performed.
REQ-025 clr while in CLEAR SHALL be ignored (no restart, no extension).
REQ-026 While busy=1, wr/ce SHALL be ignored (dropped, not queued) and all dout ports SHALL read 0.
REQ-027 ce=0 SHALL not stall the clear sequence; clear advances every clock.
REQ-028 cnt wrap from DEPTH-1 to 0 SHALL coincide with the CLEAR to IDLE transition; no entry is written twice.

Reset
REQ-029 rst=0 SHALL asynchronously force state=CLEAR, cnt=0, busy=1; dout reads 0 while rst=0.
REQ-030 After rst deasserts, CLEAR SHALL run DEPTH cycles then busy=0; array contents are all zero thereafter.
REQ-031 rst asserted mid-CLEAR or mid-IDLE SHALL restart the clear from cnt=0.
REQ-032 Array storage itself SHALL not require an asynchronous reset; zeroing is by the clear sequence only.

Verification
REQ-033 Defaults: release rst, count busy cycles -> busy high exactly 16 cycles, then all 16 registers read 0 on every port.
REQ-034 Write 32'hDEADBEEF to reg 5 with ce=1, radr all 5 in same cycle -> 0 (BYPASS=0) or DEADBEEF (BYPASS=1); next cycle all ports DEADBEEF.
REQ-035 wr=1, ce=0 to reg 3 with 32'h12345678 -> reg 3 unchanged (reads previous value).
REQ-036 Fill regs 0..15 with index*0x11111111, pulse clr, attempt write to reg 7 during busy -> 16 busy cycles, dout 0 throughout, then all regs 0 including reg 7.
REQ-037 ZERO_R0=1: write 32'hFFFFFFFF to reg 0 -> all ports reading address 0 return 0; NRD=5, AW=5 build: 32-cycle clear, independent reads on 5 ports of distinct addresses match written data.
REQ-038 Assert rst at clear cycle 8 -> busy stays high, clear restarts, busy drops 16 cycles after rst release.
